// File: rtl/hedios_rx_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : hedios_rx_packetizer_if
//  Description : Bundle of the byte-receive and packet-queue signals between
//                the UART receiver / Hedios controller and the packetizer.
//                slave  : the packetizer side (consumes bytes and pops,
//                         drives the packet head and status).
//                master : the environment side (UART receiver + controller).
//  Signals     : byte_valid      1   strobe, byte_data holds a received byte
//                byte_data       8   received byte
//                byte_frame_err  1   qualifies byte_valid: bad stop bit
//                pop_packet      1   consume FIFO head this cycle
//                packet_command  8   head command
//                packet_data     32  head data
//                queue_empty     1   FIFO holds 0 packets
//                queue_full      1   FIFO holds FIFO_DEPTH packets
//                lost_data       1   sticky: completed packet dropped
//                frame_err_count 8   saturating count of discarded frames
//  Revision    : 1.0  initial release
// ============================================================================
interface hedios_rx_packetizer_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_frame_err;
    logic        pop_packet;
    logic [7:0]  packet_command;
    logic [31:0] packet_data;
    logic        queue_empty;
    logic        queue_full;
    logic        lost_data;
    logic [7:0]  frame_err_count;

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_frame_err,
        input  pop_packet,
        output packet_command,
        output packet_data,
        output queue_empty,
        output queue_full,
        output lost_data,
        output frame_err_count
    );

    modport master (
        output byte_valid,
        output byte_data,
        output byte_frame_err,
        output pop_packet,
        input  packet_command,
        input  packet_data,
        input  queue_empty,
        input  queue_full,
        input  lost_data,
        input  frame_err_count
    );
endinterface
`default_nettype wire

// File: rtl/hedios_rx_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : hedios_rx_packetizer
//  Description : Assembles 5-byte UART frames (command byte + 4 data bytes,
//                MSB first) into packets and queues them in a show-ahead FIFO
//                popped by the Hedios controller. Partial frames are dropped
//                on a framing error or an inter-byte timeout so that a lost
//                byte never shifts the alignment of later packets.
//  Parameters  : FIFO_DEPTH      packet slots, power of 2, >= 2
//                TIMEOUT_CYCLES  max idle cycles between bytes in a frame
//  Ports       : clk             system clock
//                rst             asynchronous, active-low reset
//                bus             hedios_rx_packetizer_if.slave (byte input,
//                                pop request, packet head and status)
//  Revision    : 1.0  initial release
// ============================================================================
module hedios_rx_packetizer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    hedios_rx_packetizer_if.slave   bus
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]   CNT_FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Frame assembly state
    // ------------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [31:0]          shift_q, shift_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic                 commit;
    logic                 discard;
    logic [7:0]           push_cmd;
    logic [31:0]          push_data;

    // ------------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------------
    logic [7:0]           cmd_mem  [FIFO_DEPTH];
    logic [31:0]          data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_inc;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 lost_q, lost_d;
    logic [7:0]           head_cmd_q, head_cmd_d;
    logic [31:0]          head_data_q, head_data_d;

    logic                 do_push;
    logic                 do_pop;

    // ------------------------------------------------------------------------
    // Frame state machine: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        cmd_d     = cmd_q;
        shift_d   = shift_q;
        err_cnt_d = err_cnt_q;
        commit    = 1'b0;
        discard   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A corrupted byte here cannot be a command; drop it silently.
                if (bus.byte_valid && !bus.byte_frame_err) begin
                    cmd_d   = bus.byte_data;
                    idx_d   = 2'd0;
                    timer_d = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (bus.byte_valid) begin
                    timer_d = '0;
                    if (bus.byte_frame_err) begin
                        discard = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        shift_d = {shift_q[23:0], bus.byte_data};
                        if (idx_q == 2'd3) begin
                            commit  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // This idle cycle brings the timer to TIMEOUT_CYCLES.
                    timer_d = '0;
                    discard = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (discard && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // The committed packet is formed from the live 5th byte so the push
    // happens in the strobe cycle itself.
    assign push_cmd  = cmd_q;
    assign push_data = {shift_q[23:0], bus.byte_data};

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
    assign do_pop     = bus.pop_packet && (count_q != '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // still accepted in that case.
    assign do_push    = commit && ((count_q != CNT_FULL) || do_pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        lost_d      = lost_q;
        head_cmd_d  = head_cmd_q;
        head_data_d = head_data_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_inc;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

        if (commit && !do_push) begin
            lost_d = 1'b1;
        end

        // Show-ahead head register. When the FIFO goes empty it simply keeps
        // the last packet, which gives the required hold behaviour.
        if (do_pop) begin
            if (count_q > CNT_W'(1)) begin
                head_cmd_d  = cmd_mem[rd_ptr_inc];
                head_data_d = data_mem[rd_ptr_inc];
            end else if (do_push) begin
                head_cmd_d  = push_cmd;
                head_data_d = push_data;
            end
        end else if ((count_q == '0) && do_push) begin
            head_cmd_d  = push_cmd;
            head_data_d = push_data;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            timer_q     <= '0;
            cmd_q       <= 8'd0;
            shift_q     <= 32'd0;
            err_cnt_q   <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lost_q      <= 1'b0;
            head_cmd_q  <= 8'd0;
            head_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lost_q      <= lost_d;
            head_cmd_q  <= head_cmd_d;
            head_data_q <= head_data_d;
        end
    end

    // Packet storage needs no reset: only slots covered by count are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            cmd_mem[wr_ptr_q]  <= push_cmd;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.packet_command  = head_cmd_q;
    assign bus.packet_data     = head_data_q;
    assign bus.queue_empty     = (count_q == '0);
    assign bus.queue_full      = (count_q == CNT_FULL);
    assign bus.lost_data       = lost_q;
    assign bus.frame_err_count = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hedios_rx_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hedios_rx_packetizer
//  Description : Self-checking bench for hedios_rx_packetizer. Expected
//                packets are queued when a frame is sent and compared
//                against the FIFO head as packets are popped.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hedios_rx_packetizer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hedios_rx_packetizer_if bus_if ();

    hedios_rx_packetizer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] data;
    } pkt_t;

    pkt_t sb[$];
    logic exp_lost;
    int   exp_errs;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        bus_if.byte_valid     = 1'b1;
        bus_if.byte_data      = b;
        bus_if.byte_frame_err = err;
        tick();
        bus_if.byte_valid     = 1'b0;
        bus_if.byte_frame_err = 1'b0;
    endtask

    task automatic sb_push(input logic [7:0] c, input logic [31:0] d);
        pkt_t p;
        p.cmd  = c;
        p.data = d;
        if (sb.size() == DEPTH) exp_lost = 1'b1;
        else                    sb.push_back(p);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input int gap);
        send_byte(c, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(gap);
            send_byte(d[31-8*i -: 8], 1'b0);
        end
        sb_push(c, d);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_empty"}, 40'(bus_if.queue_empty), 40'(sb.size() == 0));
        check({tag, "_full"},  40'(bus_if.queue_full),  40'(sb.size() == DEPTH));
        check({tag, "_lost"},  40'(bus_if.lost_data),   40'(exp_lost));
        check({tag, "_errs"},  40'(bus_if.frame_err_count), 40'(exp_errs));
    endtask

    task automatic pop_check(input string tag);
        pkt_t e;
        check({tag, "_sb_has_entry"}, 40'(sb.size() != 0), 40'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_not_empty"}, 40'(bus_if.queue_empty), 40'd0);
            check({tag, "_cmd"},  40'(bus_if.packet_command), 40'(e.cmd));
            check({tag, "_data"}, 40'(bus_if.packet_data),    40'(e.data));
            bus_if.pop_packet = 1'b1;
            tick();
            bus_if.pop_packet = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        while (sb.size() != 0) pop_check(tag);
        check({tag, "_drained_empty"}, 40'(bus_if.queue_empty), 40'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        sb.delete();
        exp_lost = 1'b0;
        exp_errs = 0;
        check("rst_empty", 40'(bus_if.queue_empty),     40'd1);
        check("rst_full",  40'(bus_if.queue_full),      40'd0);
        check("rst_lost",  40'(bus_if.lost_data),       40'd0);
        check("rst_errs",  40'(bus_if.frame_err_count), 40'd0);
        check("rst_cmd",   40'(bus_if.packet_command),  40'd0);
        check("rst_data",  40'(bus_if.packet_data),     40'd0);
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p;
        bus_if.byte_valid     = 1'b0;
        bus_if.byte_data      = 8'h00;
        bus_if.byte_frame_err = 1'b0;
        bus_if.pop_packet     = 1'b0;
        exp_lost = 1'b0;
        exp_errs = 0;
        #2;
        do_reset();

        // 1: slow frame, strobes 1000 cycles apart; visible right after 5th strobe
        send_frame(8'h11, 32'hDEADBEEF, 999);
        check_status("t1");
        pop_check("t1");
        check("t1_empty_after_pop", 40'(bus_if.queue_empty), 40'd1);
        check("t1_hold_cmd",  40'(bus_if.packet_command), 40'h11);
        check("t1_hold_data", 40'(bus_if.packet_data),    40'hDEADBEEF);
        // pop while empty is ignored
        bus_if.pop_packet = 1'b1;
        tick();
        bus_if.pop_packet = 1'b0;
        check_status("t1_pop_empty");

        // 2: inter-byte timeout exactly at TIMEOUT idle cycles
        send_byte(8'h22, 1'b0);
        idle(3);
        send_byte(8'h01, 1'b0);
        idle(TIMEOUT - 1);
        check("t2_errs_before_timeout", 40'(bus_if.frame_err_count), 40'd0);
        idle(1);
        exp_errs = 1;
        check("t2_errs_at_timeout", 40'(bus_if.frame_err_count), 40'd1);
        send_frame(8'h33, 32'h00000005, 3);
        check_status("t2");
        pop_check("t2");
        check_status("t2_done");

        // 3: framing error mid-frame, and in IDLE (not counted)
        send_byte(8'h44, 1'b0);
        idle(2);
        send_byte(8'h01, 1'b0);
        idle(2);
        send_byte(8'hFF, 1'b1);
        exp_errs = 2;
        check("t3_errs", 40'(bus_if.frame_err_count), 40'd2);
        idle(2);
        send_byte(8'h77, 1'b1);
        check_status("t3_idle_err");
        send_frame(8'h55, 32'hAABBCCDD, 2);
        check_status("t3");
        pop_check("t3");
        check_status("t3_done");

        // 4: nine frames without pops (some with back-to-back strobes)
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h80 + 8'(i), 32'h01020300 + 32'(i * 17), (i % 2 == 0) ? 0 : 1);
            idle(1);
        end
        check("t4_full", 40'(bus_if.queue_full), 40'd1);
        check("t4_lost", 40'(bus_if.lost_data),  40'd1);
        drain("t4");
        check("t4_lost_sticky", 40'(bus_if.lost_data), 40'd1);
        idle(5);
        check("t4_lost_still", 40'(bus_if.lost_data), 40'd1);
        do_reset();

        // 5: full FIFO, 5th strobe coincides with a pop
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'hA0 + 8'(i), 32'hC0DE0000 + 32'(i), 1);
        end
        check_status("t5_filled");
        send_byte(8'hBB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            send_byte(8'h10 + 8'(i), 1'b0);
        end
        idle(1);
        p = sb.pop_front();
        check("t5_head_cmd",  40'(bus_if.packet_command), 40'(p.cmd));
        check("t5_head_data", 40'(bus_if.packet_data),    40'(p.data));
        bus_if.pop_packet = 1'b1;
        send_byte(8'h99, 1'b0);
        bus_if.pop_packet = 1'b0;
        p.cmd  = 8'hBB;
        p.data = 32'h10111299;
        sb.push_back(p);
        check_status("t5_after");
        drain("t5");

        // 6: reset mid-frame after 3 bytes, then a clean frame
        send_byte(8'hC1, 1'b0);
        idle(1);
        send_byte(8'hC2, 1'b0);
        idle(1);
        send_byte(8'hC3, 1'b0);
        idle(1);
        do_reset();
        send_frame(8'hC6, 32'h12345678, 2);
        check_status("t6");
        pop_check("t6");
        check_status("t6_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
